// File: rtl/reg_file_banked.sv
// Banked register file with single/pair writes and a two-step read-modify-write incrementer.
// Define REG_FILE_BANKED_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_banked #(
  parameter  int DATA_W    = 4,
  parameter  int NUM_REGS  = 16,
  parameter  int NUM_BANKS = 2,
  localparam int AW        = $clog2(NUM_REGS),
  localparam int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                bankWe,
  input  logic [BW-1:0]       bankSel,
  output logic [BW-1:0]       curBank,
  input  logic                regWe,
  input  logic [AW-1:0]       regAddr,
  input  logic [DATA_W-1:0]   regDin,
  input  logic                pairWe,
  input  logic [AW-1:0]       pairAddr,
  input  logic [2*DATA_W-1:0] pairDin,
  input  logic                incReq,
  input  logic [AW-1:0]       incAddr,
  input  logic                incPair,
  output logic                incBusy,
  output logic                incDone,
  output logic                incZero,
  output logic                incCarry,
  output logic                collErr,
  output logic [DATA_W-1:0]   regDout,
  output logic [2*DATA_W-1:0] pairDout
);

  typedef enum logic [1:0] {IDLE, RD, WR} inc_state_e;

  localparam logic [AW-1:0] ONE = AW'(1);

  inc_state_e          state_q, state_d;
  logic [DATA_W-1:0]   mem_q [NUM_BANKS][NUM_REGS];
  logic [BW-1:0]       cur_bank_q, inc_bank_q;
  logic [AW-1:0]       inc_addr_q;
  logic                inc_pair_q;
  logic [2*DATA_W-1:0] inc_val_q;
  logic                done_q, zero_q, carry_q, coll_q;

  logic [AW-1:0]       pair_even, pair_odd, inc_even, inc_odd;
  logic [2*DATA_W-1:0] inc_res;
  logic                inc_zero, inc_carry, accept, in_rmw, same_bank, coll_hit;
  logic [BW-1:0]       bank_wrap;

  function automatic logic is_tgt(input logic [AW-1:0] a, input logic [AW-1:0] t_addr,
                                  input logic t_pair);
    return t_pair ? ((a & ~ONE) == (t_addr & ~ONE)) : (a == t_addr);
  endfunction

  assign pair_even = pairAddr & ~ONE;
  assign pair_odd  = pair_even | ONE;
  assign inc_even  = inc_addr_q & ~ONE;
  assign inc_odd   = inc_even | ONE;
  assign bank_wrap = (NUM_BANKS == 1) ? '0 : bankSel;

  assign accept    = (state_q == IDLE) && incReq;
  assign in_rmw    = (state_q == RD) || (state_q == WR);
  assign same_bank = (inc_bank_q == cur_bank_q);

  // Single-mode values carry zero upper bits, so only the low half of the sum is meaningful.
  assign inc_res   = inc_val_q + {{(2*DATA_W-1){1'b0}}, 1'b1};
  assign inc_zero  = inc_pair_q ? (inc_res == '0) : (inc_res[DATA_W-1:0] == '0);
  assign inc_carry = inc_pair_q ? (&inc_val_q) : (&inc_val_q[DATA_W-1:0]);

  assign coll_hit = in_rmw && same_bank &&
                    ((regWe && is_tgt(regAddr, inc_addr_q, inc_pair_q)) ||
                     (pairWe && (is_tgt(pair_even, inc_addr_q, inc_pair_q) ||
                                 is_tgt(pair_odd, inc_addr_q, inc_pair_q))));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (incReq) state_d = RD;
      RD:      state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cur_bank_q <= '0;
      inc_bank_q <= '0;
      inc_addr_q <= '0;
      inc_pair_q <= 1'b0;
      inc_val_q  <= '0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      if (bankWe) cur_bank_q <= bank_wrap;
      if (accept) begin
        inc_bank_q <= cur_bank_q;
        inc_addr_q <= incAddr;
        inc_pair_q <= incPair;
      end
      if (state_q == RD) begin
        inc_val_q <= inc_pair_q ? {mem_q[inc_bank_q][inc_even], mem_q[inc_bank_q][inc_odd]}
                                : {{DATA_W{1'b0}}, mem_q[inc_bank_q][inc_addr_q]};
      end
      done_q <= (state_q == WR);
      if (state_q == WR) begin
        zero_q  <= inc_zero;
        carry_q <= inc_carry;
      end
      if (coll_hit) coll_q <= 1'b1;
    end
  end

  // Later assignments win: pair beats single, increment beats both.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < NUM_REGS; r++)
          mem_q[b][r] <= '0;
    end else begin
      if (regWe) mem_q[cur_bank_q][regAddr] <= regDin;
      if (pairWe) begin
        mem_q[cur_bank_q][pair_even] <= pairDin[2*DATA_W-1:DATA_W];
        mem_q[cur_bank_q][pair_odd]  <= pairDin[DATA_W-1:0];
      end
      if (state_q == WR) begin
        if (inc_pair_q) begin
          mem_q[inc_bank_q][inc_even] <= inc_res[2*DATA_W-1:DATA_W];
          mem_q[inc_bank_q][inc_odd]  <= inc_res[DATA_W-1:0];
        end else begin
          mem_q[inc_bank_q][inc_addr_q] <= inc_res[DATA_W-1:0];
        end
      end
    end
  end

`ifdef REG_FILE_BANKED_BYPASS_EN
  function automatic logic [DATA_W-1:0] fwd(input logic [AW-1:0] a);
    logic [DATA_W-1:0] v;
    v = mem_q[cur_bank_q][a];
    if (regWe && (regAddr == a))    v = regDin;
    if (pairWe && (pair_even == a)) v = pairDin[2*DATA_W-1:DATA_W];
    if (pairWe && (pair_odd == a))  v = pairDin[DATA_W-1:0];
    if ((state_q == WR) && same_bank && is_tgt(a, inc_addr_q, inc_pair_q))
      v = (inc_pair_q && (a == inc_even)) ? inc_res[2*DATA_W-1:DATA_W] : inc_res[DATA_W-1:0];
    return v;
  endfunction

  assign regDout  = fwd(regAddr);
  assign pairDout = {fwd(pair_even), fwd(pair_odd)};
`else
  assign regDout  = mem_q[cur_bank_q][regAddr];
  assign pairDout = {mem_q[cur_bank_q][pair_even], mem_q[cur_bank_q][pair_odd]};
`endif

  assign curBank  = cur_bank_q;
  assign incBusy  = in_rmw;
  assign incDone  = done_q;
  assign incZero  = zero_q;
  assign incCarry = carry_q;
  assign collErr  = coll_q;

endmodule

// File: tb/tb_reg_file_banked.sv
// Directed and random stimulus for reg_file_banked against a cycle-level behavioural model.
module tb_reg_file_banked;

  logic       clk = 1'b0;
  logic       rstN;
  logic       bankWe;
  logic [0:0] bankSel;
  logic [0:0] curBank;
  logic       regWe;
  logic [3:0] regAddr;
  logic [3:0] regDin;
  logic       pairWe;
  logic [3:0] pairAddr;
  logic [7:0] pairDin;
  logic       incReq;
  logic [3:0] incAddr;
  logic       incPair;
  logic       incBusy, incDone, incZero, incCarry, collErr;
  logic [3:0] regDout;
  logic [7:0] pairDout;

  int total = 0;
  int bad   = 0;

  // model state: register contents, current bank, increment job and status flags
  int mm[2][16];
  int mb, mph, mib, mia, mip, mold;
  int mdone, mzero, mcarry, mcoll;

  reg_file_banked dut (
    .clk(clk), .rstN(rstN),
    .bankWe(bankWe), .bankSel(bankSel), .curBank(curBank),
    .regWe(regWe), .regAddr(regAddr), .regDin(regDin),
    .pairWe(pairWe), .pairAddr(pairAddr), .pairDin(pairDin),
    .incReq(incReq), .incAddr(incAddr), .incPair(incPair),
    .incBusy(incBusy), .incDone(incDone), .incZero(incZero), .incCarry(incCarry),
    .collErr(collErr), .regDout(regDout), .pairDout(pairDout)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 16; r++)
        mm[b][r] = 0;
    mb = 0; mph = 0; mib = 0; mia = 0; mip = 0; mold = 0;
    mdone = 0; mzero = 0; mcarry = 0; mcoll = 0;
  endtask

  function automatic bit tgt(input int a);
    return (mip != 0) ? ((a >> 1) == (mia >> 1)) : (a == mia);
  endfunction

  function automatic int mpair(input int a);
    return mm[mb][a & 14] * 16 + mm[mb][a | 1];
  endfunction

  task automatic model_edge();
    int b, r, ra, pa;
    if (!rstN) begin
      model_reset();
      return;
    end
    b  = mb;
    ra = int'(regAddr);
    pa = int'(pairAddr);
    if (mph == 1)
      mold = (mip != 0) ? mm[mib][mia & 14] * 16 + mm[mib][mia | 1] : mm[mib][mia];
    if (mph != 0 && b == mib) begin
      if (regWe && tgt(ra)) mcoll = 1;
      if (pairWe && (tgt(pa & 14) || tgt(pa | 1))) mcoll = 1;
    end
    if (regWe) mm[b][ra] = int'(regDin);
    if (pairWe) begin
      mm[b][pa & 14] = int'(pairDin) / 16;
      mm[b][pa | 1]  = int'(pairDin) % 16;
    end
    mdone = 0;
    if (mph == 2) begin
      if (mip != 0) begin
        r = (mold + 1) % 256;
        mm[mib][mia & 14] = r / 16;
        mm[mib][mia | 1]  = r % 16;
        mcarry = (mold == 255);
      end else begin
        r = (mold + 1) % 16;
        mm[mib][mia] = r;
        mcarry = (mold == 15);
      end
      mzero = (r == 0);
      mdone = 1;
      mph   = 0;
    end else if (mph == 1) begin
      mph = 2;
    end else if (incReq) begin
      mib = b; mia = int'(incAddr); mip = int'(incPair); mph = 1;
    end
    if (bankWe) mb = int'(bankSel) % 2;
  endtask

  task automatic check_all(input string tg);
    chk({tg, ".busy"},  32'(incBusy),  32'(mph != 0));
    chk({tg, ".done"},  32'(incDone),  32'(mdone));
    chk({tg, ".zero"},  32'(incZero),  32'(mzero));
    chk({tg, ".carry"}, 32'(incCarry), 32'(mcarry));
    chk({tg, ".coll"},  32'(collErr),  32'(mcoll));
    chk({tg, ".bank"},  32'(curBank),  32'(mb));
    chk({tg, ".rdout"}, 32'(regDout),  32'(mm[mb][int'(regAddr)]));
    chk({tg, ".pdout"}, 32'(pairDout), 32'(mpair(int'(pairAddr))));
  endtask

  task automatic tick(input string tg);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tg);
  endtask

  task automatic rd(input string tg, input int a, input int exp);
    regAddr = 4'(a);
    #1;
    chk(tg, 32'(regDout), 32'(exp));
  endtask

  task automatic idle_inputs();
    bankWe = 0; bankSel = 0; regWe = 0; regDin = 0; pairWe = 0; pairDin = 0;
    incReq = 0; incAddr = 0; incPair = 0;
  endtask

  initial begin
    rstN = 1'b1;
    idle_inputs();
    regAddr = 0; pairAddr = 0;
    #1 rstN = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    for (int a = 0; a < 16; a++) rd("reset_reg", a, 0);
    @(negedge clk);
    rstN = 1'b1;

    // pair write with odd address lands on R2/R3
    pairWe = 1; pairAddr = 3; pairDin = 8'hA5;
    tick("pairw");
    pairWe = 0;
    rd("pairw_r2", 2, 'hA);
    rd("pairw_r3", 3, 'h5);
    pairAddr = 2; #1;
    chk("pairw_pdout2", 32'(pairDout), 32'hA5);

    // single increment wrapping 0xF -> 0x0
    regWe = 1; regAddr = 4; regDin = 4'hF;
    tick("inc1_setup");
    regWe = 0;
    incReq = 1; incAddr = 4; incPair = 0;
    tick("inc1_acc");
    incReq = 0;
    chk("inc1_busy_rd", 32'(incBusy), 32'd1);
    tick("inc1_rd");
    chk("inc1_busy_wr", 32'(incBusy), 32'd1);
    tick("inc1_wr");
    chk("inc1_done", 32'(incDone), 32'd1);
    chk("inc1_zero", 32'(incZero), 32'd1);
    chk("inc1_carry", 32'(incCarry), 32'd1);
    chk("inc1_busy_end", 32'(incBusy), 32'd0);
    rd("inc1_r4", 4, 0);

    // pair increment 0x0F -> 0x10, second request while busy ignored
    pairWe = 1; pairAddr = 6; pairDin = 8'h0F;
    tick("inc2_setup");
    pairWe = 0;
    incReq = 1; incAddr = 7; incPair = 1;
    tick("inc2_acc");
    incAddr = 4; incPair = 0;
    tick("inc2_rd");
    tick("inc2_wr");
    incReq = 0;
    chk("inc2_done", 32'(incDone), 32'd1);
    chk("inc2_zero", 32'(incZero), 32'd0);
    chk("inc2_carry", 32'(incCarry), 32'd0);
    pairAddr = 6; #1;
    chk("inc2_pair", 32'(pairDout), 32'h10);
    tick("inc2_after");
    chk("inc2_ignored_busy", 32'(incBusy), 32'd0);
    rd("inc2_r4", 4, 0);
    chk("inc2_zero_held", 32'(incZero), 32'd0);

    // bank isolation
    bankWe = 1; bankSel = 1;
    tick("bank_sel1");
    bankWe = 0;
    chk("bank_is1", 32'(curBank), 32'd1);
    regWe = 1; regAddr = 0; regDin = 4'h7;
    tick("bank_w");
    regWe = 0;
    rd("bank1_r0_a", 0, 7);
    bankWe = 1; bankSel = 0;
    tick("bank_sel0");
    bankWe = 0;
    rd("bank0_r0", 0, 0);
    bankWe = 1; bankSel = 1;
    tick("bank_sel1b");
    bankWe = 0;
    rd("bank1_r0", 0, 7);
    bankWe = 1; bankSel = 0;
    tick("bank_back0");
    bankWe = 0;

    // register write colliding with the increment's WR edge
    regWe = 1; regAddr = 5; regDin = 4'h8;
    tick("coll_setup");
    regWe = 0;
    incReq = 1; incAddr = 5; incPair = 0;
    tick("coll_acc");
    incReq = 0;
    tick("coll_rd");
    regWe = 1; regAddr = 5; regDin = 4'h3;
    tick("coll_wr");
    regWe = 0;
    rd("coll_r5", 5, 9);
    chk("coll_flag", 32'(collErr), 32'd1);
    tick("coll_hold1");
    tick("coll_hold2");
    chk("coll_sticky", 32'(collErr), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bankWe   = ($urandom_range(0, 7) == 0);
      bankSel  = 1'($urandom);
      regWe    = ($urandom_range(0, 2) == 0);
      regAddr  = 4'($urandom);
      regDin   = 4'($urandom);
      pairWe   = ($urandom_range(0, 3) == 0);
      pairAddr = 4'($urandom);
      pairDin  = 8'($urandom);
      incReq   = ($urandom_range(0, 2) == 0);
      incAddr  = 4'($urandom);
      incPair  = 1'($urandom);
      tick("rand");
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) tick("drain");

    // reset asserted while the increment sits in RD
    bankWe = 1; bankSel = 0;
    tick("rst_bank0");
    bankWe = 0;
    regWe = 1; regAddr = 9; regDin = 4'h6;
    tick("rst_setup");
    regWe = 0;
    incReq = 1; incAddr = 9; incPair = 0;
    tick("rst_acc");
    incReq = 0;
    chk("rst_busy_before", 32'(incBusy), 32'd1);
    #10 rstN = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    for (int a = 0; a < 16; a++) rd("rst_reg", a, 0);
    tick("rst_held");
    rstN = 1'b1;
    tick("rst_rel1");
    tick("rst_rel2");
    tick("rst_rel3");
    rd("rst_r9", 9, 0);
    chk("rst_busy_after", 32'(incBusy), 32'd0);
    chk("rst_done_after", 32'(incDone), 32'd0);
    bankWe = 1; bankSel = 1;
    tick("rst_sel1");
    bankWe = 0;
    rd("rst_bank1_r0", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_banked.md
REG_FILE_BANKED -- requirements
Module: reg_file_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 4, bits per register.
REQ-002 SHALL have parameter NUM_REGS, default 16, registers per bank; even power of two >= 2; AW = clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_BANKS, default 2, independent register banks; power of two >= 1; BW = max(1, clog2(NUM_BANKS)).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port bankWe  input  1  load bankSel into the current-bank register.
REQ-007 SHALL have port bankSel  input  BW  bank number to load.
REQ-008 SHALL have port curBank  output  BW  current bank.
REQ-009 SHALL have ports regWe input 1, regAddr input AW, regDin input DATA_W  single-register write.
REQ-010 SHALL have ports pairWe input 1, pairAddr input AW, pairDin input 2*DATA_W  pair write; pairAddr LSB ignored; upper half to even register, lower half to odd register.
REQ-011 SHALL have ports incReq input 1, incAddr input AW, incPair input 1  increment request; incPair=1 increments the pair at {incAddr[AW-1:1],0} as a 2*DATA_W value.
REQ-012 SHALL have ports incBusy, incDone, incZero, incCarry, collErr  output 1 each  increment status.
REQ-013 SHALL have ports regDout output DATA_W, pairDout output 2*DATA_W  combinational reads of the current bank at regAddr / pairAddr.

Function
REQ-014 SHALL address all accesses (reads, writes, increments) to the bank held in curBank at the time of the access.
REQ-015 SHALL update curBank on the edge where bankWe=1; out-of-range bankSel wraps modulo NUM_BANKS.
REQ-016 SHALL, when regWe and pairWe target the same register in one cycle, write the pair value; non-overlapping writes both complete.
REQ-017 SHALL implement increment FSM IDLE -> RD -> WR -> IDLE; incReq is accepted only in IDLE; requests in RD/WR are ignored.
REQ-018 SHALL latch incAddr, incPair and curBank on acceptance; the RD edge captures the target value; the WR edge writes value+1 modulo 2^DATA_W (single) or 2^(2*DATA_W) (pair).
REQ-019 SHALL assert incBusy in RD and WR, and pulse incDone for the single cycle after the WR edge, with incZero=(result==0) and incCarry=(old value all ones).
REQ-020 SHALL hold incZero/incCarry until the next incDone.
REQ-021 SHALL give the WR-edge increment write priority over regWe/pairWe to the same register; the losing write is dropped.
REQ-022 SHALL set sticky collErr when regWe/pairWe touches an increment target register on the RD or WR edge; it is cleared only by reset.
REQ-023 SHALL keep regDout/pairDout combinational with zero latency; the increment result becomes visible on the cycle after WR.

Reset
REQ-024 SHALL, on rstN=0, immediately clear all registers in all banks, curBank, incZero, incCarry and collErr; force the FSM to IDLE; and drive incBusy=0, incDone=0.
REQ-025 SHALL abandon an in-flight increment without writing when reset is asserted mid-operation.

Configuration
REQ-026 SHALL, with REG_FILE_BANKED_BYPASS_EN defined, forward same-cycle write data (including the WR-edge increment result) to regDout/pairDout when the read address matches, following the REQ-016/021 priority; without it, reads return stored contents only.

Verification
REQ-027 SHALL: reset, pairWe addr=3 din=0xA5 -> R2=0xA, R3=0x5, pairDout(addr 2)=0xA5.
REQ-028 SHALL: R4=0xF, incReq addr=4 incPair=0 -> incBusy for 2 cycles, R4=0x0, incDone=1, incZero=1, incCarry=1.
REQ-029 SHALL: pair R6:R7=0x0F, pair increment -> R6:R7=0x10, incZero=0, incCarry=0; a second incReq during busy is ignored.
REQ-030 SHALL: bankWe bankSel=1, regWe addr=0 din=0x7, then bank 0 -> bank 0 R0=0, bank 1 R0=0x7.
REQ-031 SHALL: regWe addr=5 din=0x3 on the WR edge of an increment of R5=0x8 -> R5=0x9, collErr=1 until reset.
REQ-032 SHALL: rstN low during RD -> no write, incBusy=0, and all registers read 0.
